// File: rtl/float_ride_ctrl.sv
// float_ride_ctrl
// Decides whether the frog is riding the floating object, sinking in the
// water band off the object, or dead, and keeps a riding frog moving left
// in lock-step with the object.
//
// Ports
//   i_Clk, i_Rst_L              clock, asynchronous active-low reset
//   i_Floating_X/Y [5:0]        floating-object grid position (leftmost cell)
//   i_Frog_X/Y     [5:0]        frog grid position
//   i_Frog_Move                 pulse: frog controller applied a player move
//   i_Restart                   pulse: leave DEAD
//   o_Riding                    state is RIDING
//   o_Carry_Valid, o_Carry_X    carry request (see handshake note below)
//   o_Drown                     pulse on entry to DEAD
//   o_Dead                      state is DEAD
//   o_State        [1:0]        registered FSM state, for observation
//
// Handshake: o_Carry_Valid is a single-cycle pulse with no ready/backpressure.
// The frog controller must load o_Carry_X in the cycle o_Carry_Valid is high;
// o_Carry_X keeps its last value afterwards.
module float_ride_ctrl #(
    parameter int c_LOG_WIDTH   = 3,
    parameter int c_WATER_Y_MIN = 3,
    parameter int c_WATER_Y_MAX = 6,
    parameter int c_GRACE_COUNT = 12500000,
    parameter int c_MIN_X       = 0
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic [5:0] i_Floating_X,
    input  logic [5:0] i_Floating_Y,
    input  logic [5:0] i_Frog_X,
    input  logic [5:0] i_Frog_Y,
    input  logic       i_Frog_Move,
    input  logic       i_Restart,
    output logic       o_Riding,
    output logic       o_Carry_Valid,
    output logic [5:0] o_Carry_X,
    output logic       o_Drown,
    output logic       o_Dead,
    output logic [1:0] o_State
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RIDING  = 2'd1,
        SINKING = 2'd2,
        DEAD    = 2'd3
    } state_t;

    // The counter only has to reach c_GRACE_COUNT-1.
    localparam int c_CNT_W = (c_GRACE_COUNT > 1) ? $clog2(c_GRACE_COUNT) : 1;

    state_t             r_State;
    logic [c_CNT_W-1:0] r_Count;
    logic [5:0]         r_Prev_X;
    logic               r_Prev_Valid;

    logic       w_In_Water;
    logic       w_On_Obj;
    logic       w_Step;
    logic       w_Wrap;
    logic [6:0] w_Obj_End;
    logic [5:0] w_Delta;
    logic [6:0] w_Floor;
    logic [5:0] w_Carry_X;

    assign w_In_Water = (i_Frog_Y >= 6'(c_WATER_Y_MIN)) && (i_Frog_Y <= 6'(c_WATER_Y_MAX));

    // Object end computed 7 bits wide so an object near the right edge
    // does not wrap its span back to column 0.
    assign w_Obj_End = {1'b0, i_Floating_X} + 7'(c_LOG_WIDTH);
    assign w_On_Obj  = (i_Frog_Y == i_Floating_Y) &&
                       (i_Frog_X >= i_Floating_X) &&
                       ({1'b0, i_Frog_X} < w_Obj_End);

    // The object only moves left, so a rise in X means it wrapped to the
    // right edge and left the frog behind.
    assign w_Step = r_Prev_Valid && (i_Floating_X != r_Prev_X);
    assign w_Wrap = w_Step && (i_Floating_X > r_Prev_X);

    // Carry by the distance the object moved, clamped at the left column.
    assign w_Delta   = r_Prev_X - i_Floating_X;
    assign w_Floor   = {1'b0, w_Delta} + 7'(c_MIN_X);
    assign w_Carry_X = ({1'b0, i_Frog_X} < w_Floor) ? 6'(c_MIN_X) : (i_Frog_X - w_Delta);

    assign o_Riding = (r_State == RIDING);
    assign o_Dead   = (r_State == DEAD);
    assign o_State  = r_State;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State       <= IDLE;
            r_Count       <= '0;
            r_Prev_X      <= '0;
            r_Prev_Valid  <= 1'b0;
            o_Carry_Valid <= 1'b0;
            o_Carry_X     <= '0;
            o_Drown       <= 1'b0;
        end else begin
            r_Prev_X      <= i_Floating_X;
            r_Prev_Valid  <= 1'b1;
            o_Carry_Valid <= 1'b0;
            o_Drown       <= 1'b0;

            case (r_State)
                IDLE: begin
                    if (w_On_Obj) begin
                        r_State <= RIDING;
                    end else if (w_In_Water) begin
                        r_State <= SINKING;
                        r_Count <= '0;
                    end
                end

                RIDING: begin
                    if (!w_In_Water) begin
                        r_State <= IDLE;
                    end else if (w_Wrap) begin
                        r_State <= SINKING;
                        r_Count <= '0;
                    end else if (w_Step && !i_Frog_Move) begin
                        // A player move in the same cycle wins: the step is
                        // dropped and on_obj is judged on the new position.
                        if (i_Frog_X > 6'(c_MIN_X)) begin
                            o_Carry_Valid <= 1'b1;
                            o_Carry_X     <= w_Carry_X;
                        end else begin
                            // Already at the left edge: pushed off-screen.
                            r_State <= DEAD;
                            o_Drown <= 1'b1;
                        end
                    end else if (!w_On_Obj) begin
                        r_State <= SINKING;
                        r_Count <= '0;
                    end
                end

                SINKING: begin
                    // Landing on the object beats grace expiry.
                    if (w_On_Obj) begin
                        r_State <= RIDING;
                        r_Count <= '0;
                    end else if (!w_In_Water) begin
                        r_State <= IDLE;
                        r_Count <= '0;
                    end else if (r_Count == c_CNT_W'(c_GRACE_COUNT - 1)) begin
                        r_State <= DEAD;
                        r_Count <= '0;
                        o_Drown <= 1'b1;
                    end else begin
                        r_Count <= r_Count + c_CNT_W'(1);
                    end
                end

                DEAD: begin
                    if (i_Restart) begin
                        r_State <= IDLE;
                        r_Count <= '0;
                    end
                end

                default: r_State <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_ride_ctrl.sv
// Directed bench for float_ride_ctrl with a short grace period (8 clocks).
// Observed vector: {state[1:0], riding, carry_valid, drown, dead, carry_x[5:0]}
module tb_float_ride_ctrl;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RIDING  = 2'd1;
    localparam logic [1:0] S_SINKING = 2'd2;
    localparam logic [1:0] S_DEAD    = 2'd3;

    logic       i_Clk;
    logic       i_Rst_L;
    logic [5:0] i_Floating_X;
    logic [5:0] i_Floating_Y;
    logic [5:0] i_Frog_X;
    logic [5:0] i_Frog_Y;
    logic       i_Frog_Move;
    logic       i_Restart;
    logic       o_Riding;
    logic       o_Carry_Valid;
    logic [5:0] o_Carry_X;
    logic       o_Drown;
    logic       o_Dead;
    logic [1:0] o_State;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] obs;
    assign obs = {o_State, o_Riding, o_Carry_Valid, o_Drown, o_Dead, o_Carry_X};

    float_ride_ctrl #(
        .c_LOG_WIDTH  (3),
        .c_WATER_Y_MIN(3),
        .c_WATER_Y_MAX(6),
        .c_GRACE_COUNT(8),
        .c_MIN_X      (0)
    ) dut (
        .i_Clk        (i_Clk),
        .i_Rst_L      (i_Rst_L),
        .i_Floating_X (i_Floating_X),
        .i_Floating_Y (i_Floating_Y),
        .i_Frog_X     (i_Frog_X),
        .i_Frog_Y     (i_Frog_Y),
        .i_Frog_Move  (i_Frog_Move),
        .i_Restart    (i_Restart),
        .o_Riding     (o_Riding),
        .o_Carry_Valid(o_Carry_Valid),
        .o_Carry_X    (o_Carry_X),
        .o_Drown      (o_Drown),
        .o_Dead       (o_Dead),
        .o_State      (o_State)
    );

    // clock / reset
    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    function automatic logic [11:0] pk(input logic [1:0] st, input logic rid,
                                       input logic cv, input logic dr,
                                       input logic dd, input logic [5:0] cx);
        return {st, rid, cv, dr, dd, cx};
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic do_reset(input logic [5:0] fx, input logic [5:0] fy,
                            input logic [5:0] ox, input logic [5:0] oy);
        i_Rst_L      = 1'b0;
        i_Frog_X     = fx;
        i_Frog_Y     = fy;
        i_Floating_X = ox;
        i_Floating_Y = oy;
        i_Frog_Move  = 1'b0;
        i_Restart    = 1'b0;
        repeat (2) tick();
        i_Rst_L = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(6'd5, 6'd4, 6'd4, 6'd4);
        n_checks++;
        if (obs !== pk(S_IDLE, 0, 0, 0, 0, 6'd0)) begin
            n_fail++;
            $display("FAIL reset_values: observed %h expected %h", obs, pk(S_IDLE, 0, 0, 0, 0, 6'd0));
        end
    endtask

    task automatic test_carry();
        do_reset(6'd5, 6'd4, 6'd4, 6'd4);
        tick();
        n_checks++;
        if (obs !== pk(S_RIDING, 1, 0, 0, 0, 6'd0)) begin
            n_fail++;
            $display("FAIL carry_board: observed %h expected %h", obs, pk(S_RIDING, 1, 0, 0, 0, 6'd0));
        end
        i_Floating_X = 6'd3;
        tick();
        n_checks++;
        if (obs !== pk(S_RIDING, 1, 1, 0, 0, 6'd4)) begin
            n_fail++;
            $display("FAIL carry_pulse: observed %h expected %h", obs, pk(S_RIDING, 1, 1, 0, 0, 6'd4));
        end
        i_Frog_X = 6'd4;
        tick();
        n_checks++;
        if (obs !== pk(S_RIDING, 1, 0, 0, 0, 6'd4)) begin
            n_fail++;
            $display("FAIL carry_one_cycle: observed %h expected %h", obs, pk(S_RIDING, 1, 0, 0, 0, 6'd4));
        end
    endtask

    task automatic test_sink_drown();
        do_reset(6'd6, 6'd4, 6'd4, 6'd4);
        tick();
        i_Floating_X = 6'd3;
        tick();
        n_checks++;
        if (obs !== pk(S_RIDING, 1, 1, 0, 0, 6'd5)) begin
            n_fail++;
            $display("FAIL sink_carry: observed %h expected %h", obs, pk(S_RIDING, 1, 1, 0, 0, 6'd5));
        end
        tick();
        n_checks++;
        if (obs !== pk(S_SINKING, 0, 0, 0, 0, 6'd5)) begin
            n_fail++;
            $display("FAIL sink_enter: observed %h expected %h", obs, pk(S_SINKING, 0, 0, 0, 0, 6'd5));
        end
        i_Floating_X = 6'd2;
        for (int i = 1; i < 8; i++) begin
            tick();
            n_checks++;
            if (obs !== pk(S_SINKING, 0, 0, 0, 0, 6'd5)) begin
                n_fail++;
                $display("FAIL sink_grace_%0d: observed %h expected %h", i, obs, pk(S_SINKING, 0, 0, 0, 0, 6'd5));
            end
        end
        tick();
        n_checks++;
        if (obs !== pk(S_DEAD, 0, 0, 1, 1, 6'd5)) begin
            n_fail++;
            $display("FAIL sink_drown: observed %h expected %h", obs, pk(S_DEAD, 0, 0, 1, 1, 6'd5));
        end
        i_Frog_X = 6'd2;
        tick();
        tick();
        n_checks++;
        if (obs !== pk(S_DEAD, 0, 0, 0, 1, 6'd5)) begin
            n_fail++;
            $display("FAIL dead_hold: observed %h expected %h", obs, pk(S_DEAD, 0, 0, 0, 1, 6'd5));
        end
        i_Restart = 1'b1;
        tick();
        i_Restart = 1'b0;
        n_checks++;
        if (obs !== pk(S_IDLE, 0, 0, 0, 0, 6'd5)) begin
            n_fail++;
            $display("FAIL restart_idle: observed %h expected %h", obs, pk(S_IDLE, 0, 0, 0, 0, 6'd5));
        end
        tick();
        n_checks++;
        if (obs !== pk(S_RIDING, 1, 0, 0, 0, 6'd5)) begin
            n_fail++;
            $display("FAIL restart_reboard: observed %h expected %h", obs, pk(S_RIDING, 1, 0, 0, 0, 6'd5));
        end
    endtask

    task automatic test_wrap_edge();
        do_reset(6'd0, 6'd4, 6'd0, 6'd4);
        tick();
        i_Floating_X = 6'd13;
        tick();
        n_checks++;
        if (obs !== pk(S_SINKING, 0, 0, 0, 0, 6'd0)) begin
            n_fail++;
            $display("FAIL wrap_no_carry: observed %h expected %h", obs, pk(S_SINKING, 0, 0, 0, 0, 6'd0));
        end
        // riding at column 1, then the frog sits at column 0 when the object steps
        do_reset(6'd1, 6'd4, 6'd1, 6'd4);
        tick();
        n_checks++;
        if (obs !== pk(S_RIDING, 1, 0, 0, 0, 6'd0)) begin
            n_fail++;
            $display("FAIL edge_board: observed %h expected %h", obs, pk(S_RIDING, 1, 0, 0, 0, 6'd0));
        end
        i_Frog_X     = 6'd0;
        i_Floating_X = 6'd0;
        tick();
        n_checks++;
        if (obs !== pk(S_DEAD, 0, 0, 1, 1, 6'd0)) begin
            n_fail++;
            $display("FAIL edge_pushed_off: observed %h expected %h", obs, pk(S_DEAD, 0, 0, 1, 1, 6'd0));
        end
        tick();
        n_checks++;
        if (obs !== pk(S_DEAD, 0, 0, 0, 1, 6'd0)) begin
            n_fail++;
            $display("FAIL edge_drown_pulse: observed %h expected %h", obs, pk(S_DEAD, 0, 0, 0, 1, 6'd0));
        end
    endtask

    task automatic test_move_collision();
        do_reset(6'd5, 6'd4, 6'd4, 6'd4);
        tick();
        i_Floating_X = 6'd3;
        i_Frog_X     = 6'd6;
        i_Frog_Move  = 1'b1;
        tick();
        i_Frog_Move = 1'b0;
        n_checks++;
        if (obs !== pk(S_SINKING, 0, 0, 0, 0, 6'd0)) begin
            n_fail++;
            $display("FAIL move_wins: observed %h expected %h", obs, pk(S_SINKING, 0, 0, 0, 0, 6'd0));
        end
        i_Frog_X = 6'd4;
        tick();
        n_checks++;
        if (obs !== pk(S_RIDING, 1, 0, 0, 0, 6'd0)) begin
            n_fail++;
            $display("FAIL move_reboard: observed %h expected %h", obs, pk(S_RIDING, 1, 0, 0, 0, 6'd0));
        end
    endtask

    task automatic test_dry_land();
        do_reset(6'd5, 6'd8, 6'd4, 6'd4);
        for (int i = 0; i < 4; i++) begin
            i_Floating_X = 6'(3 - i);
            tick();
            n_checks++;
            if (obs !== pk(S_IDLE, 0, 0, 0, 0, 6'd0)) begin
                n_fail++;
                $display("FAIL dry_idle_%0d: observed %h expected %h", i, obs, pk(S_IDLE, 0, 0, 0, 0, 6'd0));
            end
        end
    endtask

    task automatic test_async_reset();
        // mid-SINKING
        do_reset(6'd0, 6'd4, 6'd0, 6'd4);
        tick();
        i_Floating_X = 6'd13;
        repeat (3) tick();
        #2 i_Rst_L = 1'b0;
        #1;
        n_checks++;
        if (obs !== pk(S_IDLE, 0, 0, 0, 0, 6'd0)) begin
            n_fail++;
            $display("FAIL async_rst_sinking: observed %h expected %h", obs, pk(S_IDLE, 0, 0, 0, 0, 6'd0));
        end
        // mid-carry pulse
        do_reset(6'd5, 6'd4, 6'd4, 6'd4);
        tick();
        i_Floating_X = 6'd3;
        tick();
        #2 i_Rst_L = 1'b0;
        #1;
        n_checks++;
        if (obs !== pk(S_IDLE, 0, 0, 0, 0, 6'd0)) begin
            n_fail++;
            $display("FAIL async_rst_carry: observed %h expected %h", obs, pk(S_IDLE, 0, 0, 0, 0, 6'd0));
        end
        tick();
        i_Rst_L = 1'b1;
        tick();
        n_checks++;
        if (obs !== pk(S_RIDING, 1, 0, 0, 0, 6'd0)) begin
            n_fail++;
            $display("FAIL post_rst_first_clk: observed %h expected %h", obs, pk(S_RIDING, 1, 0, 0, 0, 6'd0));
        end
        i_Floating_X = 6'd2;
        tick();
        n_checks++;
        if (obs !== pk(S_RIDING, 1, 1, 0, 0, 6'd4)) begin
            n_fail++;
            $display("FAIL post_rst_carry: observed %h expected %h", obs, pk(S_RIDING, 1, 1, 0, 0, 6'd4));
        end
    endtask

    initial begin
        test_reset();
        test_carry();
        test_sink_drown();
        test_wrap_edge();
        test_move_collision();
        test_dry_land();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/float_ride_ctrl.md
# float_ride_ctrl

Consumes the floating-object position produced by the floating controller (6-bit grid X/Y, stepping left one cell per slow tick and wrapping to the right edge). It also consumes the frog's grid position from the frog controller. The block decides whether the frog is riding the floating object, carrying it, sinking or drowned. When the frog is riding, it emits one-cycle carry requests that move the frog left in lock-step with the object, and it raises a drown event when the frog sits in the water band off the object for longer than a grace period.

## Interface
- c_LOG_WIDTH, 3 — object length in cells, occupying X .. X+c_LOG_WIDTH-1
- c_WATER_Y_MIN, 3 — first water row (inclusive)
- c_WATER_Y_MAX, 6 — last water row (inclusive)
- c_GRACE_COUNT, 12500000 — clocks the frog survives in water off the object
- c_MIN_X, 0 — leftmost legal frog column
- i_Clk  in  1  system clock
- i_Rst_L  in  1  reset, asynchronous assert, active-low; one clock, asynchronous active-low reset (fixed)
- i_Floating_X  in  6  floating-object column
- i_Floating_Y  in  6  floating-object row
- i_Frog_X  in  6  current frog column
- i_Frog_Y  in  6  current frog row
- i_Frog_Move  in  1  one-cycle pulse: frog controller applied a player move this cycle
- i_Restart  in  1  one-cycle pulse: leave DEAD
- o_Riding  out  1  high while state is RIDING
- o_Carry_Valid  out  1  one-cycle pulse: frog controller must load o_Carry_X
- o_Carry_X  out  6  carried frog column
- o_Drown  out  1  one-cycle pulse on entry to DEAD
- o_Dead  out  1  high while state is DEAD

## Operation
- in_water = c_WATER_Y_MIN <= i_Frog_Y <= c_WATER_Y_MAX.
- on_obj = (i_Frog_Y == i_Floating_Y) && i_Frog_X >= i_Floating_X && i_Frog_X < i_Floating_X + c_LOG_WIDTH. The sum is computed 7 bits wide, with no 6-bit overflow.
- Step detect: r_Prev_X holds last i_Floating_X. r_Prev_Valid is cleared on reset and set on the first clock after reset.
  - step = r_Prev_Valid && i_Floating_X != r_Prev_X.
  - wrap = step && i_Floating_X > r_Prev_X.
- States: IDLE, RIDING, SINKING, DEAD (2-bit encoding).
- IDLE:
  - on_obj goes to RIDING.
  - in_water && !on_obj goes to SINKING, with grace counter cleared.
  - otherwise stay.
- RIDING:
  - On a step without wrap and without i_Frog_Move:
    - if i_Frog_X > c_MIN_X, issue carry with o_Carry_X = i_Frog_X − (r_Prev_X − i_Floating_X), clamped at c_MIN_X; stay RIDING.
    - if i_Frog_X == c_MIN_X, frog is pushed off-screen: go to DEAD with o_Drown.
  - On wrap: no carry; go to SINKING (object leaves from under frog).
  - !on_obj && in_water goes to SINKING.
  - !in_water goes to IDLE.
- SINKING:
  - Counter increments each clock.
  - on_obj goes to RIDING, counter cleared.
  - !in_water goes to IDLE.
  - Counter reaching c_GRACE_COUNT−1 goes to DEAD.
- DEAD:
  - o_Dead high; no carries; inputs ignored except i_Restart.
  - i_Restart goes to IDLE, counter cleared.
- Simultaneous i_Frog_Move and step in RIDING: the player move wins and the carry is suppressed for that step. on_obj is re-evaluated on following cycles with the new frog position. The missed step is not replayed.
- Simultaneous grace expiry and on_obj in SINKING: on_obj wins, go to RIDING.

## Timing
- All outputs are registered.
- Reset values: state IDLE, counter 0, r_Prev_X 0, r_Prev_Valid 0, o_Riding 0, o_Carry_Valid 0, o_Carry_X 0, o_Drown 0, o_Dead 0.
- Carry latency: i_Floating_X changes in cycle N; o_Carry_Valid/o_Carry_X are valid in cycle N+1 for exactly one cycle. o_Carry_X holds its value afterwards.
- o_Drown is high the single cycle o_Dead first rises.
- o_Riding and o_Dead follow state with one register delay, i.e. equal to the registered state.
- Reset asserted mid-operation immediately forces all reset values, including a pending carry or drown.
- First clock after reset only samples r_Prev_X; no step can be detected in that cycle.

## Test plan
- Frog (5,4), object (4,4), object steps 4→3 → o_Riding=1, next cycle o_Carry_Valid=1 for one cycle, o_Carry_X=4.
- Frog (6,4), object (4,4) then moves away to X=2 via steps (frog not re-carried) → SINKING. After exactly c_GRACE_COUNT (set to 8) clocks, o_Drown is a one-cycle pulse and o_Dead=1 until i_Restart, then IDLE.
- Riding frog at X=0, object at X=0 steps 0→13 (wrap) → no carry, SINKING. Separately, riding frog at X=0 with a non-wrap step → DEAD, o_Drown pulse.
- i_Frog_Move and object step in the same cycle while RIDING → o_Carry_Valid stays 0; state follows the new frog position.
- Frog at Y=8 (not water) → stays IDLE, no carries, o_Dead=0, regardless of object steps.
- Assert i_Rst_L low mid-SINKING and mid-carry pulse → all outputs 0 asynchronously. The first step after release is ignored until r_Prev_Valid=1.
